radio_fifo_sched: RTL and testbench

RADIO_FIFO_SCHED -- requirements
Module: radio_fifo_sched

---
 rtl/radio_fifo_pkg.sv | 32 +++
 rtl/radio_fifo_sched_rr_arb2.sv | 44 ++++
 rtl/radio_fifo_sched.sv | 145 ++++++++++++++
 tb/tb_radio_fifo_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radio_fifo_pkg.sv
// Shared types and defaults for the radio sample-FIFO drain scheduler.
package radio_fifo_pkg;

  localparam int DEFAULT_DATA_W    = 32;
  localparam int DEFAULT_CNT_W     = 11;
  localparam int DEFAULT_BURST_LEN = 8;

  // Raw state encodings, kept as plain constants for older code that
  // compares against numeric state values.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_P_RD  = 3'd1;
  localparam logic [2:0] ST_P_CAP = 3'd2;
  localparam logic [2:0] ST_P_ACK = 3'd3;
  localparam logic [2:0] ST_S_RD  = 3'd4;
  localparam logic [2:0] ST_S_OUT = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    P_RD  = ST_P_RD,
    P_CAP = ST_P_CAP,
    P_ACK = ST_P_ACK,
    S_RD  = ST_S_RD,
    S_OUT = ST_S_OUT
  } state_t;

  // Requester identity used by the round-robin arbiter.
  typedef enum logic {
    REQ_POLL = 1'b0,
    REQ_STRM = 1'b1
  } req_id_t;

endpackage

// File: rtl/radio_fifo_sched_rr_arb2.sv
// Two-way round-robin arbiter between the register-poll and stream-burst
// requesters. On a tie the requester that was not served last wins.
module rr_arb2
  import radio_fifo_pkg::*;
(
  input  logic aclk,
  input  logic areset,
  input  logic req_poll,
  input  logic req_strm,
  input  logic accept,
  output logic grant_poll,
  output logic grant_strm
);

  req_id_t last_served;

  // Grant a lone requester directly; break ties against the last winner.
  always_comb begin
    grant_poll = 1'b0;
    grant_strm = 1'b0;
    if (req_poll && req_strm) begin
      if (last_served == REQ_STRM) begin
        grant_poll = 1'b1;
      end else begin
        grant_strm = 1'b1;
      end
    end else begin
      grant_poll = req_poll;
      grant_strm = req_strm;
    end
  end

  // Remember who was served; starts as stream so poll wins the first tie.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      last_served <= REQ_STRM;
    end else if (accept && grant_poll) begin
      last_served <= REQ_POLL;
    end else if (accept && grant_strm) begin
      last_served <= REQ_STRM;
    end
  end

endmodule

// File: rtl/radio_fifo_sched.sv
// Drains a standard (non-FWFT) sample FIFO either one word at a time for
// register polls or in fixed-length AXI-Stream bursts, arbitrated fairly.
module radio_fifo_sched
  import radio_fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              poll_req,
  output logic              poll_ack,
  output logic [DATA_W-1:0] poll_data,
  output logic              poll_err,
  input  logic              strm_en,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [15:0]       burst_cnt,
  output logic [15:0]       uflow_cnt
);

  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
  localparam logic [7:0]       BURST_LEN_B = 8'(BURST_LEN);

  state_t            state;
  logic [7:0]        beats_left;
  logic              poll_block;
  logic              out_first;
  logic [DATA_W-1:0] tdata_q;
  logic              in_idle;
  logic              poll_elig;
  logic              strm_elig;
  logic              grant_poll;
  logic              grant_strm;

  assign in_idle   = (state == IDLE);
  assign poll_elig = in_idle && poll_req && !poll_block;
  assign strm_elig = in_idle && strm_en && (fifo_count >= BURST_LEN_C);

  // The FIFO word arrives the cycle after the read strobe, so the first
  // S_OUT cycle forwards fifo_dout and later stall cycles replay the copy.
  assign m_axis_tdata = out_first ? fifo_dout : tdata_q;

  rr_arb2 u_arb (
    .aclk       (aclk),
    .areset     (areset),
    .req_poll   (poll_elig),
    .req_strm   (strm_elig),
    .accept     (in_idle),
    .grant_poll (grant_poll),
    .grant_strm (grant_strm)
  );

  // Main scheduler FSM with all registered outputs and event counters.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      fifo_rd_en    <= 1'b0;
      poll_ack      <= 1'b0;
      poll_err      <= 1'b0;
      poll_data     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      tdata_q       <= '0;
      out_first     <= 1'b0;
      beats_left    <= '0;
      poll_block    <= 1'b0;
      burst_cnt     <= '0;
      uflow_cnt     <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      out_first  <= 1'b0;
      poll_block <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_poll) begin
            if (fifo_empty) begin
              state     <= P_ACK;
              poll_ack  <= 1'b1;
              poll_err  <= 1'b1;
              poll_data <= '0;
              uflow_cnt <= uflow_cnt + 16'd1;
            end else begin
              state      <= P_RD;
              fifo_rd_en <= 1'b1;
            end
          end else if (grant_strm) begin
            state      <= S_RD;
            fifo_rd_en <= 1'b1;
            beats_left <= BURST_LEN_B;
          end
        end
        P_RD: begin
          state <= P_CAP;
        end
        P_CAP: begin
          poll_data <= fifo_dout;
          poll_ack  <= 1'b1;
          poll_err  <= 1'b0;
          state     <= P_ACK;
        end
        P_ACK: begin
          poll_ack   <= 1'b0;
          poll_err   <= 1'b0;
          poll_block <= 1'b1;
          state      <= IDLE;
        end
        S_RD: begin
          state         <= S_OUT;
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= (beats_left == 8'd1);
          out_first     <= 1'b1;
        end
        S_OUT: begin
          if (out_first) begin
            tdata_q <= fifo_dout;
          end
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            beats_left    <= beats_left - 8'd1;
            if (beats_left == 8'd1) begin
              burst_cnt <= burst_cnt + 16'd1;
              state     <= IDLE;
            end else begin
              state      <= S_RD;
              fifo_rd_en <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radio_fifo_sched.sv
// Directed bench for radio_fifo_sched with a behavioural standard FIFO.
module tb_radio_fifo_sched;

  localparam int DATA_W    = 32;
  localparam int CNT_W     = 11;
  localparam int BURST_LEN = 8;

  logic              aclk = 1'b0;
  logic              areset;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              poll_req;
  logic              poll_ack;
  logic [DATA_W-1:0] poll_data;
  logic              poll_err;
  logic              strm_en;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic [15:0]       burst_cnt;
  logic [15:0]       uflow_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  radio_fifo_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .fifo_empty    (fifo_empty),
    .fifo_count    (fifo_count),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_dout     (fifo_dout),
    .poll_req      (poll_req),
    .poll_ack      (poll_ack),
    .poll_data     (poll_data),
    .poll_err      (poll_err),
    .strm_en       (strm_en),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .burst_cnt     (burst_cnt),
    .uflow_cnt     (uflow_cnt)
  );

  always #5 aclk = ~aclk;

  // Behavioural non-FWFT FIFO: data appears the cycle after a read strobe.
  logic [DATA_W-1:0] fmem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_count = CNT_W'(wr_ptr - rd_ptr);
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge aclk) begin
    if (fifo_rd_en) begin
      fifo_dout <= fmem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor: strobes, stream beats and poll completions, sampled mid-cycle.
  int                rd_pulses     = 0;
  int                rd_when_empty = 0;
  logic [DATA_W-1:0] beat_q [$];
  logic              last_q [$];
  logic [DATA_W-1:0] ack_q  [$];
  int                ev_q   [$];

  always @(negedge aclk) begin
    if (fifo_rd_en) begin
      rd_pulses <= rd_pulses + 1;
      if (fifo_empty) rd_when_empty <= rd_when_empty + 1;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      beat_q.push_back(m_axis_tdata);
      last_q.push_back(m_axis_tlast);
      if (m_axis_tlast) ev_q.push_back(1);
    end
    if (poll_ack) begin
      ack_q.push_back(poll_data);
      ev_q.push_back(0);
    end
  end

  typedef struct {
    logic        setup;
    logic [31:0] load_base;
    int          load_n;
    logic        poll_req;
    logic        strm_en;
    logic        tready;
    logic        e_rd;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_pdata;
    logic        e_tvalid;
    logic        e_tlast;
    logic [31:0] e_tdata;
    logic [15:0] e_uflow;
    logic [15:0] e_burst;
  } vec_t;

  vec_t vecs [$];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flushLoad(input logic [31:0] base, input int n);
    wr_ptr = rd_ptr;
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr % 256] = base + 32'(i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic doReset(input logic [31:0] base, input int n);
    areset        = 1'b1;
    poll_req      = 1'b0;
    strm_en       = 1'b0;
    m_axis_tready = 1'b0;
    tick();
    flushLoad(base, n);
    tick();
    areset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.setup) doReset(v.load_base, v.load_n);
    poll_req      = v.poll_req;
    strm_en       = v.strm_en;
    m_axis_tready = v.tready;
  endtask

  function automatic vec_t mkv(input logic pr, input logic se, input logic tr,
                               input logic erd, input logic eack, input logic eerr,
                               input logic [31:0] epd, input logic etv, input logic etl,
                               input logic [31:0] etd, input logic [15:0] eu,
                               input logic [15:0] eb);
    vec_t v;
    v.setup = 1'b0; v.load_base = '0; v.load_n = 0;
    v.poll_req = pr; v.strm_en = se; v.tready = tr;
    v.e_rd = erd; v.e_ack = eack; v.e_err = eerr; v.e_pdata = epd;
    v.e_tvalid = etv; v.e_tlast = etl; v.e_tdata = etd;
    v.e_uflow = eu; v.e_burst = eb;
    return v;
  endfunction

  task automatic pushSetup(input vec_t v, input logic [31:0] base, input int n);
    vec_t w;
    w = v;
    w.setup = 1'b1; w.load_base = base; w.load_n = n;
    vecs.push_back(w);
  endtask

  // Per-cycle table: inputs of row i act at the edge ending cycle i.
  task automatic buildTable();
    // Poll with data; req held one cycle past ack must not re-pop.
    pushSetup(mkv(1,0,0, 0,0,0,0, 0,0,0, 0,0), 32'h1, 4);
    vecs.push_back(mkv(1,0,0, 1,0,0,0, 0,0,0, 0,0));
    vecs.push_back(mkv(1,0,0, 0,0,0,0, 0,0,0, 0,0));
    vecs.push_back(mkv(1,0,0, 0,1,0,32'h1, 0,0,0, 0,0));
    vecs.push_back(mkv(1,0,0, 0,0,0,0, 0,0,0, 0,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,0, 0,0,0, 0,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,0, 0,0,0, 0,0));
    // Poll on an empty FIFO: immediate error ack.
    pushSetup(mkv(1,0,0, 0,0,0,0, 0,0,0, 0,0), 32'h0, 0);
    vecs.push_back(mkv(1,0,0, 0,1,1,32'h0, 0,0,0, 1,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,0, 0,0,0, 1,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,0, 0,0,0, 1,0));
    // Full-rate burst of 8 words with tready always high.
    pushSetup(mkv(0,1,1, 0,0,0,0, 0,0,0, 0,0), 32'hA0, 8);
    vecs.push_back(mkv(0,1,1, 1,0,0,0, 0,0,0, 0,0));
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mkv(0,1,1, 0,0,0,0, 1,(k == 7),32'hA0 + 32'(k), 0,0));
      if (k < 7) vecs.push_back(mkv(0,1,1, 1,0,0,0, 0,0,0, 0,0));
    end
    vecs.push_back(mkv(0,1,1, 0,0,0,0, 0,0,0, 0,1));
    vecs.push_back(mkv(0,1,1, 0,0,0,0, 0,0,0, 0,1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rp, nb, ne, na, cyc, nlast;
    areset        = 1'b1;
    poll_req      = 1'b0;
    strm_en       = 1'b0;
    m_axis_tready = 1'b0;
    #1;
    checkOutput("reset rd_en",  fifo_rd_en,    0);
    checkOutput("reset ack",    poll_ack,      0);
    checkOutput("reset tvalid", m_axis_tvalid, 0);
    checkOutput("reset tdata",  m_axis_tdata,  0);
    checkOutput("reset burst",  burst_cnt,     0);
    tick();

    buildTable();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge aclk);
      checkOutput($sformatf("v%0d rd_en", i),  fifo_rd_en,    vecs[i].e_rd);
      checkOutput($sformatf("v%0d ack", i),    poll_ack,      vecs[i].e_ack);
      checkOutput($sformatf("v%0d err", i),    poll_err,      vecs[i].e_err);
      checkOutput($sformatf("v%0d tvalid", i), m_axis_tvalid, vecs[i].e_tvalid);
      checkOutput($sformatf("v%0d tlast", i),  m_axis_tlast,  vecs[i].e_tlast);
      checkOutput($sformatf("v%0d uflow", i),  uflow_cnt,     vecs[i].e_uflow);
      checkOutput($sformatf("v%0d burst", i),  burst_cnt,     vecs[i].e_burst);
      if (vecs[i].e_ack)    checkOutput($sformatf("v%0d pdata", i), poll_data, vecs[i].e_pdata);
      if (vecs[i].e_tvalid) checkOutput($sformatf("v%0d tdata", i), m_axis_tdata, vecs[i].e_tdata);
      tick();
    end

    // Seven words is one short of a burst; the eighth word starts it.
    doReset(32'h70, 7);
    rp = rd_pulses;
    strm_en = 1'b1; m_axis_tready = 1'b1;
    repeat (10) tick();
    checkOutput("count7 rd pulses", 32'(rd_pulses - rp), 0);
    checkOutput("count7 tvalid", m_axis_tvalid, 0);
    flushLoad(32'h70, 8);
    cyc = 0;
    while (burst_cnt != 16'd1 && cyc < 40) begin tick(); cyc++; end
    checkOutput("count8 burst_cnt", burst_cnt, 1);

    // Stall tready for several cycles in the middle of a burst.
    doReset(32'hB0, 8);
    rp = rd_pulses; nb = beat_q.size();
    strm_en = 1'b1; m_axis_tready = 1'b1;
    cyc = 0;
    while (beat_q.size() - nb < 3 && cyc < 50) begin tick(); cyc++; end
    m_axis_tready = 1'b0;
    cyc = 0;
    while (!m_axis_tvalid && cyc < 10) begin @(negedge aclk); cyc++; end
    checkOutput("stall tvalid up", m_axis_tvalid, 1);
    #1;
    ne = rd_pulses;
    for (int s = 0; s < 5; s++) begin
      @(negedge aclk);
      checkOutput($sformatf("stall%0d tvalid", s), m_axis_tvalid, 1);
      checkOutput($sformatf("stall%0d tdata", s),  m_axis_tdata,  32'hB3);
    end
    #1;
    checkOutput("stall no extra rd", 32'(rd_pulses - ne), 0);
    tick();
    m_axis_tready = 1'b1;
    cyc = 0;
    while (burst_cnt != 16'd1 && cyc < 40) begin tick(); cyc++; end
    checkOutput("stall burst_cnt", burst_cnt, 1);
    checkOutput("stall beat count", 32'(beat_q.size() - nb), 8);
    checkOutput("stall rd pulses", 32'(rd_pulses - rp), 8);
    if (beat_q.size() - nb >= 8) begin
      for (int k = 0; k < 8; k++) begin
        checkOutput($sformatf("stall beat%0d data", k), beat_q[nb + k], 32'hB0 + 32'(k));
        checkOutput($sformatf("stall beat%0d last", k), last_q[nb + k], (k == 7));
      end
    end

    // Poll and stream tie repeatedly: service must alternate, poll first.
    doReset(32'hC0, 24);
    ne = ev_q.size(); na = ack_q.size(); nb = beat_q.size();
    poll_req = 1'b1; strm_en = 1'b1; m_axis_tready = 1'b1;
    cyc = 0;
    while (ev_q.size() - ne < 4 && cyc < 200) begin tick(); cyc++; end
    poll_req = 1'b0; strm_en = 1'b0;
    checkOutput("tie event count", 32'(ev_q.size() - ne >= 4), 1);
    if (ev_q.size() - ne >= 4 && ack_q.size() - na >= 2 && beat_q.size() - nb >= 8) begin
      checkOutput("tie ev0 poll",   32'(ev_q[ne]),     0);
      checkOutput("tie ev1 stream", 32'(ev_q[ne + 1]), 1);
      checkOutput("tie ev2 poll",   32'(ev_q[ne + 2]), 0);
      checkOutput("tie ev3 stream", 32'(ev_q[ne + 3]), 1);
      checkOutput("tie poll0 data", ack_q[na],     32'hC0);
      checkOutput("tie poll1 data", ack_q[na + 1], 32'hC9);
      checkOutput("tie beat0 data", beat_q[nb],     32'hC1);
      checkOutput("tie beat7 data", beat_q[nb + 7], 32'hC8);
    end
    repeat (25) tick();

    // Reset while the fourth beat is on the bus.
    doReset(32'hD0, 8);
    nb = beat_q.size();
    strm_en = 1'b1; m_axis_tready = 1'b1;
    cyc = 0;
    while (beat_q.size() - nb < 3 && cyc < 50) begin tick(); cyc++; end
    tick();
    checkOutput("abort beat4 tvalid", m_axis_tvalid, 1);
    checkOutput("abort beat4 tdata",  m_axis_tdata,  32'hD3);
    areset = 1'b1;
    #1;
    checkOutput("abort rd_en",  fifo_rd_en,    0);
    checkOutput("abort tvalid", m_axis_tvalid, 0);
    checkOutput("abort tlast",  m_axis_tlast,  0);
    checkOutput("abort tdata",  m_axis_tdata,  0);
    checkOutput("abort ack",    poll_ack,      0);
    checkOutput("abort burst",  burst_cnt,     0);
    tick();
    areset = 1'b0; strm_en = 1'b0; m_axis_tready = 1'b0;
    repeat (3) tick();
    checkOutput("abort idle tvalid", m_axis_tvalid, 0);
    checkOutput("abort beats seen", 32'(beat_q.size() - nb), 3);
    nlast = 0;
    for (int k = nb; k < beat_q.size(); k++) if (last_q[k]) nlast++;
    checkOutput("abort no tlast", 32'(nlast), 0);
    poll_req = 1'b1;
    repeat (3) tick();
    @(negedge aclk);
    checkOutput("abort poll ack",  poll_ack,  1);
    checkOutput("abort poll data", poll_data, 32'hD4);
    tick();
    poll_req = 1'b0;
    repeat (3) tick();

    checkOutput("rd_en while empty", 32'(rd_when_empty), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
